vga_out_pipe: RTL and testbench

//  Parametrised VGA output stage between rbzero's pixel/sync outputs and the
//  8 dedicated output pins. Reduces IN_BPC colour to OUT_BPC per channel with
//  4x4 ordered (Bayer) dither and forces black outside the visible area.

---
 rtl/vga_out_pkg.sv | 39 +++
 rtl/vga_dither_ch.sv | 36 +++
 rtl/vga_out_pipe.sv | 148 ++++++++++++++
 tb/tb_vga_out_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_out_pkg.sv
// Shared definitions for the VGA output pipe: Bayer threshold table,
// pin layout selectors, idle sync levels and the pin mapping helper.
package vga_out_pkg;

    localparam int PINMAP_TINYVGA = 0;
    localparam int PINMAP_PLAIN   = 1;

    localparam logic IDLE_HSYNC_N = 1'b1;
    localparam logic IDLE_VSYNC_N = 1'b1;

    // Row-major 4x4 ordered dither thresholds, index {row, col}
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    function automatic logic [3:0] bayer4x4(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return BAYER[{row, col}];
    endfunction

    function automatic logic [7:0] map_pins(
        input int         pinmap,
        input logic       hs_n,
        input logic       vs_n,
        input logic [1:0] r,
        input logic [1:0] g,
        input logic [1:0] b
    );
        if (pinmap == PINMAP_PLAIN)
            return {hs_n, vs_n, b, g, r};
        return {hs_n, b[0], g[0], r[0], vs_n, b[1], g[1], r[1]};
    endfunction

endpackage

// File: rtl/vga_dither_ch.sv
// One colour channel: optional threshold add with saturation, then
// truncation to OUT_BPC and forced black outside the visible area.
// Ports: in_i (IN_BPC colour), t_scaled_i (scaled threshold),
//   visible_i, en_i (dither enable), out_o (OUT_BPC colour). Combinational.
module vga_dither_ch #(
    parameter int IN_BPC  = 6,
    parameter int OUT_BPC = 2
) (
    input  logic [IN_BPC-1:0]  in_i,
    input  logic [IN_BPC-1:0]  t_scaled_i,
    input  logic               visible_i,
    input  logic               en_i,
    output logic [OUT_BPC-1:0] out_o
);

    localparam int D = IN_BPC - OUT_BPC;

    logic [IN_BPC:0]   sum;
    logic [IN_BPC-1:0] sat;

    assign sum = {1'b0, in_i}
               + {1'b0, (en_i ? t_scaled_i : {IN_BPC{1'b0}})};

    // Carry out means the threshold pushed past full scale: clamp
    assign sat = sum[IN_BPC] ? {IN_BPC{1'b1}} : sum[IN_BPC-1:0];

    assign out_o = visible_i ? sat[IN_BPC-1:D] : {OUT_BPC{1'b0}};

    generate
        if (D > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^sat[D-1:0];
        end
    endgenerate

endmodule

// File: rtl/vga_out_pipe.sv
// VGA output stage: Bayer dither + blanking, sync-aligned pipe, pin map.
// Ports: clk, reset (async high), i_reg (1 = pins from last register),
//   i_dither_en, i_hpos/i_vpos, i_visible, i_hsync_n/i_vsync_n,
//   i_r/i_g/i_b -> o_pins (mapped VGA pins), o_frame (frame counter).
// Macro VGA_OUT_TEMPORAL_DITHER_EN rotates the threshold column per frame.
module vga_out_pipe
    import vga_out_pkg::*;
#(
    parameter int IN_BPC      = 6,
    parameter int OUT_BPC     = 2,
    parameter int PIPE_STAGES = 2,
    parameter int PINMAP      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_reg,
    input  logic              i_dither_en,
    input  logic [9:0]        i_hpos,
    input  logic [9:0]        i_vpos,
    input  logic              i_visible,
    input  logic              i_hsync_n,
    input  logic              i_vsync_n,
    input  logic [IN_BPC-1:0] i_r,
    input  logic [IN_BPC-1:0] i_g,
    input  logic [IN_BPC-1:0] i_b,
    output logic [7:0]        o_pins,
    output logic [1:0]        o_frame
);

    localparam int D = IN_BPC - OUT_BPC;

    typedef struct packed {
        logic               hs_n;
        logic               vs_n;
        logic               vis;
        logic [OUT_BPC-1:0] r;
        logic [OUT_BPC-1:0] g;
        logic [OUT_BPC-1:0] b;
    } pix_t;

    localparam pix_t PIX_IDLE = '{
        hs_n: IDLE_HSYNC_N,
        vs_n: IDLE_VSYNC_N,
        vis:  1'b0,
        r:    '0,
        g:    '0,
        b:    '0
    };

    pix_t              pipe_q [PIPE_STAGES];
    pix_t              stage_d;
    pix_t              pix_early;
    pix_t              pix_out;
    logic [1:0]        frame_q;
    logic [1:0]        frame_d;
    logic [1:0]        col;
    logic [3:0]        t_raw;
    logic [IN_BPC-1:0] t_scaled;
    logic [OUT_BPC-1:0] r_c;
    logic [OUT_BPC-1:0] g_c;
    logic [OUT_BPC-1:0] b_c;

`ifdef VGA_OUT_TEMPORAL_DITHER_EN
    assign col = i_hpos[1:0] ^ frame_q;
`else
    assign col = i_hpos[1:0];
`endif

    assign t_raw = bayer4x4(i_vpos[1:0], col);

    // Align the 4-bit threshold with the D bits that get dropped
    generate
        if (D >= 4) begin : g_up
            assign t_scaled = IN_BPC'(t_raw) << (D - 4);
        end else begin : g_dn
            logic [3:0] t_sh;
            assign t_sh     = t_raw >> (4 - D);
            assign t_scaled = IN_BPC'(t_sh);
        end
    endgenerate

    vga_dither_ch #(.IN_BPC(IN_BPC), .OUT_BPC(OUT_BPC)) u_r (
        .in_i(i_r), .t_scaled_i(t_scaled), .visible_i(i_visible),
        .en_i(i_dither_en), .out_o(r_c)
    );
    vga_dither_ch #(.IN_BPC(IN_BPC), .OUT_BPC(OUT_BPC)) u_g (
        .in_i(i_g), .t_scaled_i(t_scaled), .visible_i(i_visible),
        .en_i(i_dither_en), .out_o(g_c)
    );
    vga_dither_ch #(.IN_BPC(IN_BPC), .OUT_BPC(OUT_BPC)) u_b (
        .in_i(i_b), .t_scaled_i(t_scaled), .visible_i(i_visible),
        .en_i(i_dither_en), .out_o(b_c)
    );

    always_comb begin
        stage_d      = PIX_IDLE;
        stage_d.hs_n = i_hsync_n;
        stage_d.vs_n = i_vsync_n;
        stage_d.vis  = i_visible;
        stage_d.r    = r_c;
        stage_d.g    = g_c;
        stage_d.b    = b_c;
    end

    // Falling vsync edge, judged against the copy held in stage 1
    always_comb begin
        frame_d = frame_q;
        if (pipe_q[0].vs_n && !i_vsync_n)
            frame_d = frame_q + 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE_STAGES; k++)
                pipe_q[k] <= PIX_IDLE;
            frame_q <= 2'd0;
        end else begin
            pipe_q[0] <= stage_d;
            for (int k = 1; k < PIPE_STAGES; k++)
                pipe_q[k] <= pipe_q[k-1];
            frame_q <= frame_d;
        end
    end

    // Bypassing the final register taps one stage earlier
    generate
        if (PIPE_STAGES >= 2) begin : g_tap
            assign pix_early = pipe_q[PIPE_STAGES-2];
        end else begin : g_comb
            assign pix_early = stage_d;
        end
    endgenerate

    assign pix_out = i_reg ? pipe_q[PIPE_STAGES-1] : pix_early;

    assign o_pins = map_pins(
        PINMAP, pix_out.hs_n, pix_out.vs_n,
        pix_out.r[OUT_BPC-1 -: 2],
        pix_out.g[OUT_BPC-1 -: 2],
        pix_out.b[OUT_BPC-1 -: 2]
    );

    assign o_frame = frame_q;

    logic unused_ok;
    assign unused_ok = ^{i_hpos[9:2], i_vpos[9:2], pix_out.vis};

endmodule

// File: tb/tb_vga_out_pipe.sv
// Self-checking bench for vga_out_pipe: directed scenarios plus random
// traffic against a behavioural model, PINMAP 0 and 1 instances side by side.
module tb_vga_out_pipe;

    localparam int IN_BPC      = 6;
    localparam int OUT_BPC     = 2;
    localparam int PIPE_STAGES = 2;
    localparam int D           = IN_BPC - OUT_BPC;
    localparam int MAXV        = (1 << IN_BPC) - 1;
`ifdef VGA_OUT_TEMPORAL_DITHER_EN
    localparam bit TEMPORAL = 1'b1;
`else
    localparam bit TEMPORAL = 1'b0;
`endif

    localparam int BT [16] = '{0, 8, 2, 10, 12, 4, 14, 6,
                               3, 11, 1, 9, 15, 7, 13, 5};

    typedef struct {
        bit hs;
        bit vs;
        int r;
        int g;
        int b;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_reg;
    logic              i_dither_en;
    logic [9:0]        i_hpos;
    logic [9:0]        i_vpos;
    logic              i_visible;
    logic              i_hsync_n;
    logic              i_vsync_n;
    logic [IN_BPC-1:0] i_r;
    logic [IN_BPC-1:0] i_g;
    logic [IN_BPC-1:0] i_b;
    logic [7:0]        pins0;
    logic [7:0]        pins1;
    logic [1:0]        frame0;
    logic [1:0]        frame1;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t hist[$];
    int   m_frame;
    bit   m_prev_vs;

    always #5 clk = ~clk;

    vga_out_pipe #(.IN_BPC(IN_BPC), .OUT_BPC(OUT_BPC),
                   .PIPE_STAGES(PIPE_STAGES), .PINMAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .i_reg(i_reg),
        .i_dither_en(i_dither_en), .i_hpos(i_hpos), .i_vpos(i_vpos),
        .i_visible(i_visible), .i_hsync_n(i_hsync_n),
        .i_vsync_n(i_vsync_n), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_pins(pins0), .o_frame(frame0)
    );

    vga_out_pipe #(.IN_BPC(IN_BPC), .OUT_BPC(OUT_BPC),
                   .PIPE_STAGES(PIPE_STAGES), .PINMAP(1)) u_dut1 (
        .clk(clk), .reset(reset), .i_reg(i_reg),
        .i_dither_en(i_dither_en), .i_hpos(i_hpos), .i_vpos(i_vpos),
        .i_visible(i_visible), .i_hsync_n(i_hsync_n),
        .i_vsync_n(i_vsync_n), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_pins(pins1), .o_frame(frame1)
    );

    function automatic int chan(int x, int h, int v, int fr,
                                bit vis, bit en);
        int col, t, ts, s;
        if (!vis) return 0;
        if (!en || D == 0) return x >> D;
        col = (h % 4) ^ (TEMPORAL ? fr : 0);
        t   = BT[(v % 4) * 4 + col];
        ts  = (D >= 4) ? t * (1 << (D - 4)) : t / (1 << (4 - D));
        s   = x + ts;
        if (s > MAXV) s = MAXV;
        return s >> D;
    endfunction

    function automatic logic [7:0] pins_of(int pm, ent_t e);
        logic [1:0] r, g, b;
        r = e.r[1:0];
        g = e.g[1:0];
        b = e.b[1:0];
        if (pm == 1) return {e.hs, e.vs, b, g, r};
        return {e.hs, b[0], g[0], r[0], e.vs, b[1], g[1], r[1]};
    endfunction

    function automatic ent_t sel_exp();
        return i_reg ? hist[PIPE_STAGES-1] : hist[PIPE_STAGES-2];
    endfunction

    task automatic set_in(int h, int v, bit vis, bit hs, bit vs,
                          int r, int g, int b, bit en);
        i_hpos      = 10'(h);
        i_vpos      = 10'(v);
        i_visible   = vis;
        i_hsync_n   = hs;
        i_vsync_n   = vs;
        i_r         = IN_BPC'(r);
        i_g         = IN_BPC'(g);
        i_b         = IN_BPC'(b);
        i_dither_en = en;
    endtask

    task automatic model_init();
        ent_t e;
        e = '{hs: 1'b1, vs: 1'b1, r: 0, g: 0, b: 0};
        hist.delete();
        for (int k = 0; k < PIPE_STAGES; k++) hist.push_front(e);
        m_frame   = 0;
        m_prev_vs = 1'b1;
    endtask

    // One clock edge: capture the sampled inputs into the model, settle
    task automatic tick();
        ent_t e;
        int h, v;
        @(posedge clk);
        h    = int'(i_hpos);
        v    = int'(i_vpos);
        e.hs = i_hsync_n;
        e.vs = i_vsync_n;
        e.r  = chan(int'(i_r), h, v, m_frame, i_visible, i_dither_en);
        e.g  = chan(int'(i_g), h, v, m_frame, i_visible, i_dither_en);
        e.b  = chan(int'(i_b), h, v, m_frame, i_visible, i_dither_en);
        hist.push_front(e);
        if (hist.size() > PIPE_STAGES + 1) void'(hist.pop_back());
        if (m_prev_vs && !i_vsync_n) m_frame = (m_frame + 1) % 4;
        m_prev_vs = i_vsync_n;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_reg = 1'b1;
        set_in(0, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b1);
        #2;
        n_tests++;
        if (pins0 !== 8'h88) begin
            n_fail++;
            $display("FAIL reset_pins0_reg: got %h want 88", pins0);
        end
        n_tests++;
        if (pins1 !== 8'hC0) begin
            n_fail++;
            $display("FAIL reset_pins1_reg: got %h want C0", pins1);
        end
        n_tests++;
        if (frame0 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_frame: got %0d want 0", frame0);
        end
        i_reg = 1'b0;
        #1;
        n_tests++;
        if (pins0 !== 8'h88) begin
            n_fail++;
            $display("FAIL reset_pins0_bypass: got %h want 88", pins0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();
    endtask

    task automatic test_dither();
        int cases [4][5] = '{
            '{6'h1F, 0, 0, 1, 1},
            '{6'h1F, 1, 0, 1, 2},
            '{6'h1F, 1, 0, 0, 1},
            '{6'h3F, 0, 3, 1, 3}
        };
        i_reg = 1'b0;
        foreach (cases[i]) begin
            set_in(cases[i][1], cases[i][2], 1'b1, 1'b1, 1'b1,
                   cases[i][0], 0, 0, cases[i][3][0]);
            tick();
            n_tests++;
            if (int'(pins1[1:0]) !== cases[i][4]) begin
                n_fail++;
                $display("FAIL dither_case%0d: r_out=%0d want %0d",
                         i, pins1[1:0], cases[i][4]);
            end
        end
    endtask

    task automatic test_blank_map();
        i_reg = 1'b0;
        set_in(0, 0, 1'b1, 1'b0, 1'b1, 6'h3F, 0, 0, 1'b1);
        tick();
        n_tests++;
        if (pins0 !== 8'h19) begin
            n_fail++;
            $display("FAIL blank_visible: got %h want 19", pins0);
        end
        set_in(0, 0, 1'b0, 1'b0, 1'b1, 6'h3F, 0, 0, 1'b1);
        tick();
        n_tests++;
        if (pins0 !== 8'h08) begin
            n_fail++;
            $display("FAIL blank_hidden: got %h want 08", pins0);
        end
    endtask

    task automatic test_latency();
        i_reg = 1'b1;
        set_in(0, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b1);
        repeat (3) tick();
        set_in(0, 0, 1'b1, 1'b0, 1'b1, 6'h3F, 0, 0, 1'b1);
        tick();
        n_tests++;
        if (pins0 !== 8'h88) begin
            n_fail++;
            $display("FAIL latency_reg_n1: got %h want 88", pins0);
        end
        i_reg = 1'b0;
        #1;
        n_tests++;
        if (pins0 !== 8'h19) begin
            n_fail++;
            $display("FAIL latency_bypass_n1: got %h want 19", pins0);
        end
        i_reg = 1'b1;
        tick();
        n_tests++;
        if (pins0 !== 8'h19) begin
            n_fail++;
            $display("FAIL latency_reg_n2: got %h want 19", pins0);
        end
        n_tests++;
        if (pins1 !== 8'h43) begin
            n_fail++;
            $display("FAIL latency_plain_n2: got %h want 43", pins1);
        end
    endtask

    task automatic test_random();
        ent_t e;
        bit   vs;
        vs = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) vs = ~vs;
            i_reg = 1'($urandom_range(0, 1));
            set_in($urandom_range(0, 1023), $urandom_range(0, 1023),
                   $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                   vs, $urandom_range(0, MAXV), $urandom_range(0, MAXV),
                   $urandom_range(0, MAXV), $urandom_range(0, 3) != 0);
            tick();
            e = sel_exp();
            n_tests++;
            if (pins0 !== pins_of(0, e)) begin
                n_fail++;
                $display("FAIL rand_pins0 n=%0d: got %h want %h",
                         n, pins0, pins_of(0, e));
            end
            n_tests++;
            if (pins1 !== pins_of(1, e)) begin
                n_fail++;
                $display("FAIL rand_pins1 n=%0d: got %h want %h",
                         n, pins1, pins_of(1, e));
            end
            n_tests++;
            if (int'(frame0) !== m_frame) begin
                n_fail++;
                $display("FAIL rand_frame n=%0d: got %0d want %0d",
                         n, frame0, m_frame);
            end
        end
    endtask

    task automatic test_frame();
        int   seq [5] = '{1, 2, 3, 0, 1};
        ent_t e;
        reset = 1'b1;
        set_in(0, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b1);
        #3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();
        i_reg = 1'b1;
        for (int p = 0; p < 5; p++) begin
            set_in(0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1);
            repeat (3) tick();
            set_in(0, 0, 1'b1, 1'b1, 1'b1, 8, 8, 8, 1'b1);
            repeat (3) tick();
            n_tests++;
            if (int'(frame0) !== seq[p]) begin
                n_fail++;
                $display("FAIL frame_pulse%0d: got %0d want %0d",
                         p, frame0, seq[p]);
            end
            e = sel_exp();
            n_tests++;
            if (pins0 !== pins_of(0, e)) begin
                n_fail++;
                $display("FAIL frame_dither%0d: got %h want %h",
                         p, pins0, pins_of(0, e));
            end
        end
    endtask

    task automatic test_async_reset();
        i_reg = 1'b1;
        set_in(0, 0, 1'b1, 1'b0, 1'b1, 6'h3F, 0, 0, 1'b1);
        repeat (2) tick();
        n_tests++;
        if (pins0 !== 8'h19) begin
            n_fail++;
            $display("FAIL areset_pre: got %h want 19", pins0);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (pins0 !== 8'h88) begin
            n_fail++;
            $display("FAIL areset_pins0: got %h want 88", pins0);
        end
        n_tests++;
        if (pins1 !== 8'hC0) begin
            n_fail++;
            $display("FAIL areset_pins1: got %h want C0", pins1);
        end
        n_tests++;
        if (frame0 !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_frame: got %0d want 0", frame0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();
        set_in(0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        tick();
        n_tests++;
        if (frame0 !== 2'd1) begin
            n_fail++;
            $display("FAIL areset_first_edge: got %0d want 1", frame0);
        end
    endtask

    initial begin
        test_reset();
        test_dither();
        test_blank_map();
        test_latency();
        test_random();
        test_frame();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
